// File: rtl/axi4_retime_pkg.sv
// Shared channel indices and payload width helpers for the AXI4 retiming slice.
package axi4_retime_pkg;

    localparam int CH_AW  = 0;
    localparam int CH_W   = 1;
    localparam int CH_B   = 2;
    localparam int CH_AR  = 3;
    localparam int CH_R   = 4;
    localparam int NUM_CH = 5;

    localparam int AXI_LEN_W   = 8;
    localparam int AXI_BURST_W = 2;
    localparam int AXI_RESP_W  = 2;

    // Address payload: {addr, id, len, burst}; shared by AW and AR.
    function automatic int ax_width(input int addr_w, input int id_w);
        return addr_w + id_w + AXI_LEN_W + AXI_BURST_W;
    endfunction

    // Write data payload: {data, strb, last}.
    function automatic int w_width(input int data_w);
        return data_w + data_w / 8 + 1;
    endfunction

    // Write response payload: {resp, id}.
    function automatic int b_width(input int id_w);
        return AXI_RESP_W + id_w;
    endfunction

    // Read data payload: {data, resp, id, last}.
    function automatic int r_width(input int data_w, input int id_w);
        return data_w + AXI_RESP_W + id_w + 1;
    endfunction

endpackage

// File: rtl/axi4_retime_fifo.sv
// Registered-handshake FIFO: ready and valid come purely from the stored count,
// so both sides of the channel are cut into separate timing paths.
module axi4_retime_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             src_valid_i,
    output logic             src_ready_o,
    input  logic [WIDTH-1:0] src_data_i,
    output logic             snk_valid_o,
    input  logic             snk_ready_i,
    output logic [WIDTH-1:0] snk_data_o,
    output logic             empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR   = PTR_W'(DEPTH - 1);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push;
    logic             pop;

    // A pop while full does not open ready in the same cycle.
    assign src_ready_o = (count_q < FULL_COUNT);
    assign snk_valid_o = (count_q != '0);
    assign empty_o     = (count_q == '0);
    assign push        = src_valid_i && src_ready_o;
    assign pop         = snk_valid_o && snk_ready_i;
    assign snk_data_o  = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately left out of reset; emptied pointers make it unreachable.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= src_data_i;
        end
    end

endmodule

// File: rtl/axi4_retime_param.sv
// AXI4 register slice: each of the five channels is either a FIFO buffer or a
// plain wire-through, chosen per channel by PASS_MASK.
module axi4_retime_param
    import axi4_retime_pkg::*;
#(
    parameter int         ADDR_W    = 32,
    parameter int         DATA_W    = 32,
    parameter int         ID_W      = 4,
    parameter int         DEPTH     = 2,
    parameter logic [4:0] PASS_MASK = 5'b00000
) (
    input  logic                clk_i,
    input  logic                rst_i,

    input  logic                inport_awvalid_i,
    input  logic [ADDR_W-1:0]   inport_awaddr_i,
    input  logic [ID_W-1:0]     inport_awid_i,
    input  logic [7:0]          inport_awlen_i,
    input  logic [1:0]          inport_awburst_i,
    output logic                inport_awready_o,
    input  logic                inport_wvalid_i,
    input  logic [DATA_W-1:0]   inport_wdata_i,
    input  logic [DATA_W/8-1:0] inport_wstrb_i,
    input  logic                inport_wlast_i,
    output logic                inport_wready_o,
    output logic                inport_bvalid_o,
    output logic [1:0]          inport_bresp_o,
    output logic [ID_W-1:0]     inport_bid_o,
    input  logic                inport_bready_i,
    input  logic                inport_arvalid_i,
    input  logic [ADDR_W-1:0]   inport_araddr_i,
    input  logic [ID_W-1:0]     inport_arid_i,
    input  logic [7:0]          inport_arlen_i,
    input  logic [1:0]          inport_arburst_i,
    output logic                inport_arready_o,
    output logic                inport_rvalid_o,
    output logic [DATA_W-1:0]   inport_rdata_o,
    output logic [1:0]          inport_rresp_o,
    output logic [ID_W-1:0]     inport_rid_o,
    output logic                inport_rlast_o,
    input  logic                inport_rready_i,

    output logic                outport_awvalid_o,
    output logic [ADDR_W-1:0]   outport_awaddr_o,
    output logic [ID_W-1:0]     outport_awid_o,
    output logic [7:0]          outport_awlen_o,
    output logic [1:0]          outport_awburst_o,
    input  logic                outport_awready_i,
    output logic                outport_wvalid_o,
    output logic [DATA_W-1:0]   outport_wdata_o,
    output logic [DATA_W/8-1:0] outport_wstrb_o,
    output logic                outport_wlast_o,
    input  logic                outport_wready_i,
    input  logic                outport_bvalid_i,
    input  logic [1:0]          outport_bresp_i,
    input  logic [ID_W-1:0]     outport_bid_i,
    output logic                outport_bready_o,
    output logic                outport_arvalid_o,
    output logic [ADDR_W-1:0]   outport_araddr_o,
    output logic [ID_W-1:0]     outport_arid_o,
    output logic [7:0]          outport_arlen_o,
    output logic [1:0]          outport_arburst_o,
    input  logic                outport_arready_i,
    input  logic                outport_rvalid_i,
    input  logic [DATA_W-1:0]   outport_rdata_i,
    input  logic [1:0]          outport_rresp_i,
    input  logic [ID_W-1:0]     outport_rid_i,
    input  logic                outport_rlast_i,
    output logic                outport_rready_o,

    output logic                idle_o
);

    localparam int AW_W = ax_width(ADDR_W, ID_W);
    localparam int W_W  = w_width(DATA_W);
    localparam int B_W  = b_width(ID_W);
    localparam int AR_W = ax_width(ADDR_W, ID_W);
    localparam int R_W  = r_width(DATA_W, ID_W);

    logic [AW_W-1:0]   aw_src_data, aw_snk_data;
    logic [W_W-1:0]    w_src_data,  w_snk_data;
    logic [B_W-1:0]    b_src_data,  b_snk_data;
    logic [AR_W-1:0]   ar_src_data, ar_snk_data;
    logic [R_W-1:0]    r_src_data,  r_snk_data;
    logic [NUM_CH-1:0] ch_empty;

    // B and R flow downstream-to-upstream, so their source is the outport side.
    assign aw_src_data = {inport_awaddr_i, inport_awid_i, inport_awlen_i, inport_awburst_i};
    assign w_src_data  = {inport_wdata_i, inport_wstrb_i, inport_wlast_i};
    assign b_src_data  = {outport_bresp_i, outport_bid_i};
    assign ar_src_data = {inport_araddr_i, inport_arid_i, inport_arlen_i, inport_arburst_i};
    assign r_src_data  = {outport_rdata_i, outport_rresp_i, outport_rid_i, outport_rlast_i};

    assign {outport_awaddr_o, outport_awid_o, outport_awlen_o, outport_awburst_o} = aw_snk_data;
    assign {outport_wdata_o, outport_wstrb_o, outport_wlast_o}                     = w_snk_data;
    assign {inport_bresp_o, inport_bid_o}                                          = b_snk_data;
    assign {outport_araddr_o, outport_arid_o, outport_arlen_o, outport_arburst_o} = ar_snk_data;
    assign {inport_rdata_o, inport_rresp_o, inport_rid_o, inport_rlast_o}         = r_snk_data;

    if (PASS_MASK[CH_AW]) begin : g_aw_pass
        assign outport_awvalid_o = inport_awvalid_i;
        assign inport_awready_o  = outport_awready_i;
        assign aw_snk_data       = aw_src_data;
        assign ch_empty[CH_AW]   = 1'b1;
    end else begin : g_aw_fifo
        axi4_retime_fifo #(.WIDTH(AW_W), .DEPTH(DEPTH)) u_fifo (
            .clk_i(clk_i), .rst_i(rst_i),
            .src_valid_i(inport_awvalid_i), .src_ready_o(inport_awready_o), .src_data_i(aw_src_data),
            .snk_valid_o(outport_awvalid_o), .snk_ready_i(outport_awready_i), .snk_data_o(aw_snk_data),
            .empty_o(ch_empty[CH_AW])
        );
    end

    if (PASS_MASK[CH_W]) begin : g_w_pass
        assign outport_wvalid_o = inport_wvalid_i;
        assign inport_wready_o  = outport_wready_i;
        assign w_snk_data       = w_src_data;
        assign ch_empty[CH_W]   = 1'b1;
    end else begin : g_w_fifo
        axi4_retime_fifo #(.WIDTH(W_W), .DEPTH(DEPTH)) u_fifo (
            .clk_i(clk_i), .rst_i(rst_i),
            .src_valid_i(inport_wvalid_i), .src_ready_o(inport_wready_o), .src_data_i(w_src_data),
            .snk_valid_o(outport_wvalid_o), .snk_ready_i(outport_wready_i), .snk_data_o(w_snk_data),
            .empty_o(ch_empty[CH_W])
        );
    end

    if (PASS_MASK[CH_B]) begin : g_b_pass
        assign inport_bvalid_o  = outport_bvalid_i;
        assign outport_bready_o = inport_bready_i;
        assign b_snk_data       = b_src_data;
        assign ch_empty[CH_B]   = 1'b1;
    end else begin : g_b_fifo
        axi4_retime_fifo #(.WIDTH(B_W), .DEPTH(DEPTH)) u_fifo (
            .clk_i(clk_i), .rst_i(rst_i),
            .src_valid_i(outport_bvalid_i), .src_ready_o(outport_bready_o), .src_data_i(b_src_data),
            .snk_valid_o(inport_bvalid_o), .snk_ready_i(inport_bready_i), .snk_data_o(b_snk_data),
            .empty_o(ch_empty[CH_B])
        );
    end

    if (PASS_MASK[CH_AR]) begin : g_ar_pass
        assign outport_arvalid_o = inport_arvalid_i;
        assign inport_arready_o  = outport_arready_i;
        assign ar_snk_data       = ar_src_data;
        assign ch_empty[CH_AR]   = 1'b1;
    end else begin : g_ar_fifo
        axi4_retime_fifo #(.WIDTH(AR_W), .DEPTH(DEPTH)) u_fifo (
            .clk_i(clk_i), .rst_i(rst_i),
            .src_valid_i(inport_arvalid_i), .src_ready_o(inport_arready_o), .src_data_i(ar_src_data),
            .snk_valid_o(outport_arvalid_o), .snk_ready_i(outport_arready_i), .snk_data_o(ar_snk_data),
            .empty_o(ch_empty[CH_AR])
        );
    end

    if (PASS_MASK[CH_R]) begin : g_r_pass
        assign inport_rvalid_o  = outport_rvalid_i;
        assign outport_rready_o = inport_rready_i;
        assign r_snk_data       = r_src_data;
        assign ch_empty[CH_R]   = 1'b1;
    end else begin : g_r_fifo
        axi4_retime_fifo #(.WIDTH(R_W), .DEPTH(DEPTH)) u_fifo (
            .clk_i(clk_i), .rst_i(rst_i),
            .src_valid_i(outport_rvalid_i), .src_ready_o(outport_rready_o), .src_data_i(r_src_data),
            .snk_valid_o(inport_rvalid_o), .snk_ready_i(inport_rready_i), .snk_data_o(r_snk_data),
            .empty_o(ch_empty[CH_R])
        );
    end

    // Wire-through channels report empty, so an all-pass slice is always idle.
    assign idle_o = &ch_empty;

endmodule

// File: tb/tb_axi4_retime_param.sv
// Scoreboard bench for axi4_retime_param across three configurations:
// inst0 DEPTH=2, inst1 DEPTH=4 with R wire-through, inst2 DEPTH=8.
`timescale 1ns/1ps
module tb_axi4_retime_param;

    localparam int NI = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [NI-1:0]       rst;
    logic [NI-1:0]       iaw_valid, iaw_ready, iw_valid, iw_last, iw_ready;
    logic [NI-1:0][31:0] iaw_addr, iar_addr, oaw_addr, oar_addr;
    logic [NI-1:0][3:0]  iaw_id, iar_id, oaw_id, oar_id, iw_strb, ow_strb;
    logic [NI-1:0][7:0]  iaw_len, iar_len, oaw_len, oar_len;
    logic [NI-1:0][1:0]  iaw_burst, iar_burst, oaw_burst, oar_burst;
    logic [NI-1:0][31:0] iw_data, ow_data, ir_data, or_data;
    logic [NI-1:0]       ib_valid, ib_ready, iar_valid, iar_ready, ir_valid, ir_last, ir_ready;
    logic [NI-1:0][1:0]  ib_resp, ob_resp, ir_resp, or_resp;
    logic [NI-1:0][3:0]  ib_id, ob_id, ir_id, or_id;
    logic [NI-1:0]       oaw_valid, oaw_ready, ow_valid, ow_last, ow_ready;
    logic [NI-1:0]       ob_valid, ob_ready, oar_valid, oar_ready, or_valid, or_last, or_ready;
    logic [NI-1:0]       idle;

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        localparam int         DEP = (gi == 0) ? 2 : ((gi == 1) ? 4 : 8);
        localparam logic [4:0] PM  = (gi == 1) ? 5'b10000 : 5'b00000;
        axi4_retime_param #(.ADDR_W(32), .DATA_W(32), .ID_W(4), .DEPTH(DEP), .PASS_MASK(PM)) u_dut (
            .clk_i(clk), .rst_i(rst[gi]),
            .inport_awvalid_i(iaw_valid[gi]), .inport_awaddr_i(iaw_addr[gi]), .inport_awid_i(iaw_id[gi]),
            .inport_awlen_i(iaw_len[gi]), .inport_awburst_i(iaw_burst[gi]), .inport_awready_o(iaw_ready[gi]),
            .inport_wvalid_i(iw_valid[gi]), .inport_wdata_i(iw_data[gi]), .inport_wstrb_i(iw_strb[gi]),
            .inport_wlast_i(iw_last[gi]), .inport_wready_o(iw_ready[gi]),
            .inport_bvalid_o(ib_valid[gi]), .inport_bresp_o(ib_resp[gi]), .inport_bid_o(ib_id[gi]),
            .inport_bready_i(ib_ready[gi]),
            .inport_arvalid_i(iar_valid[gi]), .inport_araddr_i(iar_addr[gi]), .inport_arid_i(iar_id[gi]),
            .inport_arlen_i(iar_len[gi]), .inport_arburst_i(iar_burst[gi]), .inport_arready_o(iar_ready[gi]),
            .inport_rvalid_o(ir_valid[gi]), .inport_rdata_o(ir_data[gi]), .inport_rresp_o(ir_resp[gi]),
            .inport_rid_o(ir_id[gi]), .inport_rlast_o(ir_last[gi]), .inport_rready_i(ir_ready[gi]),
            .outport_awvalid_o(oaw_valid[gi]), .outport_awaddr_o(oaw_addr[gi]), .outport_awid_o(oaw_id[gi]),
            .outport_awlen_o(oaw_len[gi]), .outport_awburst_o(oaw_burst[gi]), .outport_awready_i(oaw_ready[gi]),
            .outport_wvalid_o(ow_valid[gi]), .outport_wdata_o(ow_data[gi]), .outport_wstrb_o(ow_strb[gi]),
            .outport_wlast_o(ow_last[gi]), .outport_wready_i(ow_ready[gi]),
            .outport_bvalid_i(ob_valid[gi]), .outport_bresp_i(ob_resp[gi]), .outport_bid_i(ob_id[gi]),
            .outport_bready_o(ob_ready[gi]),
            .outport_arvalid_o(oar_valid[gi]), .outport_araddr_o(oar_addr[gi]), .outport_arid_o(oar_id[gi]),
            .outport_arlen_o(oar_len[gi]), .outport_arburst_o(oar_burst[gi]), .outport_arready_i(oar_ready[gi]),
            .outport_rvalid_i(or_valid[gi]), .outport_rdata_i(or_data[gi]), .outport_rresp_i(or_resp[gi]),
            .outport_rid_i(or_id[gi]), .outport_rlast_i(or_last[gi]), .outport_rready_o(or_ready[gi]),
            .idle_o(idle[gi])
        );
    end

    int tests = 0;
    int fails = 0;
    int ar_pops = 0;
    bit ar_done = 1'b0;

    logic [63:0] exp_aw0 [$];
    logic [63:0] exp_w1  [$];
    logic [63:0] exp_b1  [$];
    logic [63:0] exp_ar2 [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic unexpected(input string name, input logic [63:0] act);
        tests++;
        fails++;
        $display("[TB] FAIL %s: beat 0x%0h emerged with nothing expected", name, act);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitors: pop the scoreboard whenever a sink handshake is presented.
    always @(negedge clk) begin
        if (!rst[0] && oaw_valid[0] && oaw_ready[0]) begin
            if (exp_aw0.size() == 0) unexpected("aw0_beat", {oaw_addr[0], oaw_id[0], oaw_len[0], oaw_burst[0]});
            else check("aw0_beat", {oaw_addr[0], oaw_id[0], oaw_len[0], oaw_burst[0]}, exp_aw0.pop_front());
            $display("[TB] aw0 pop addr=0x%0h id=%0d", oaw_addr[0], oaw_id[0]);
        end
        if (!rst[1] && ow_valid[1] && ow_ready[1]) begin
            if (exp_w1.size() == 0) unexpected("w1_beat", {ow_data[1], ow_strb[1], ow_last[1]});
            else check("w1_beat", {ow_data[1], ow_strb[1], ow_last[1]}, exp_w1.pop_front());
            $display("[TB] w1 pop data=0x%0h last=%0d", ow_data[1], ow_last[1]);
        end
        if (!rst[1] && ib_valid[1] && ib_ready[1]) begin
            if (exp_b1.size() == 0) unexpected("b1_beat", {ib_resp[1], ib_id[1]});
            else check("b1_beat", {ib_resp[1], ib_id[1]}, exp_b1.pop_front());
            $display("[TB] b1 pop resp=%0d id=%0d", ib_resp[1], ib_id[1]);
        end
        if (!rst[2] && oar_valid[2] && oar_ready[2]) begin
            ar_pops++;
            if (exp_ar2.size() == 0) unexpected("ar2_beat", {oar_addr[2], oar_id[2], oar_len[2], oar_burst[2]});
            else check("ar2_beat", {oar_addr[2], oar_id[2], oar_len[2], oar_burst[2]}, exp_ar2.pop_front());
            $display("[TB] ar2 pop addr=0x%0h id=%0d len=%0d", oar_addr[2], oar_id[2], oar_len[2]);
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = '1;
        iaw_valid = '0; iaw_addr = '0; iaw_id = '0; iaw_len = '0; iaw_burst = '0;
        iw_valid = '0; iw_data = '0; iw_strb = '0; iw_last = '0;
        iar_valid = '0; iar_addr = '0; iar_id = '0; iar_len = '0; iar_burst = '0;
        ob_valid = '0; ob_resp = '0; ob_id = '0;
        or_valid = '0; or_data = '0; or_resp = '0; or_id = '0; or_last = '0;
        oaw_ready = '1; ow_ready = '1; ib_ready = '1; oar_ready = '1; ir_ready = '1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_awready", iaw_ready[0], 1'b1);
        check("rst_awvalid", oaw_valid[0], 1'b0);
        check("rst_bvalid",  ib_valid[0],  1'b0);
        check("rst_idle",    idle[0],      1'b0 | 1'b1);
        check("rst_wready2", iw_ready[2],  1'b1);
        step();
        rst = '0;

        // Single AW beat: one cycle to sink valid, idle low until popped.
        oaw_ready[0] = 1'b0;
        iaw_valid[0] = 1'b1; iaw_addr[0] = 32'h1000; iaw_id[0] = 4'd3; iaw_len[0] = 8'd0; iaw_burst[0] = 2'd1;
        @(negedge clk);
        check("aw0_ready_empty", iaw_ready[0], 1'b1);
        check("aw0_no_bypass",   oaw_valid[0], 1'b0);
        check("aw0_idle_before", idle[0],      1'b1);
        exp_aw0.push_back({32'h1000, 4'd3, 8'd0, 2'd1});
        step();
        iaw_valid[0] = 1'b0;
        @(negedge clk);
        check("aw0_valid_lat1", oaw_valid[0], 1'b1);
        check("aw0_addr",       oaw_addr[0],  32'h1000);
        check("aw0_id",         oaw_id[0],    4'd3);
        check("aw0_idle_busy",  idle[0],      1'b0);
        step();
        @(negedge clk);
        check("aw0_idle_held", idle[0], 1'b0);
        step();
        oaw_ready[0] = 1'b1;
        step();
        @(negedge clk);
        check("aw0_idle_after", idle[0],      1'b1);
        check("aw0_empty",      oaw_valid[0], 1'b0);

        // Full DEPTH=2 FIFO: pop plus offered push refuses the push for one cycle.
        step();
        oaw_ready[0] = 1'b0;
        iaw_valid[0] = 1'b1; iaw_addr[0] = 32'h1100; iaw_id[0] = 4'd1;
        @(negedge clk);
        check("aw0_fill_a", iaw_ready[0], 1'b1);
        exp_aw0.push_back({32'h1100, 4'd1, 8'd0, 2'd1});
        step();
        iaw_addr[0] = 32'h1200; iaw_id[0] = 4'd2;
        @(negedge clk);
        check("aw0_fill_b", iaw_ready[0], 1'b1);
        exp_aw0.push_back({32'h1200, 4'd2, 8'd0, 2'd1});
        step();
        iaw_addr[0] = 32'h1300; iaw_id[0] = 4'd4;
        oaw_ready[0] = 1'b1;
        @(negedge clk);
        check("aw0_full_refuse", iaw_ready[0], 1'b0);
        step();
        oaw_ready[0] = 1'b0;
        @(negedge clk);
        check("aw0_ready_next", iaw_ready[0], 1'b1);
        exp_aw0.push_back({32'h1300, 4'd4, 8'd0, 2'd1});
        step();
        iaw_valid[0] = 1'b0;
        @(negedge clk);
        check("aw0_full_again", iaw_ready[0], 1'b0);
        step();
        oaw_ready[0] = 1'b1;
        repeat (3) step();
        @(negedge clk);
        check("aw0_drained", exp_aw0.size(), 0);
        check("aw0_idle_end", idle[0], 1'b1);

        // DEPTH=4 W channel with the sink stalled: only four of six beats land.
        step();
        ow_ready[1] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            logic [31:0] d;
            logic        lst;
            d = 32'hA000_0000 + 32'(i);
            lst = (i == 3);
            iw_valid[1] = 1'b1; iw_data[1] = d; iw_strb[1] = 4'hF; iw_last[1] = lst;
            @(negedge clk);
            check($sformatf("w1_ready_%0d", i), iw_ready[1], (i < 4));
            if (i < 4) exp_w1.push_back({d, 4'hF, lst});
            step();
        end
        iw_valid[1] = 1'b0;
        @(negedge clk);
        check("w1_stay_full", iw_ready[1], 1'b0);
        step();
        ow_ready[1] = 1'b1;
        repeat (5) step();
        @(negedge clk);
        check("w1_drained", exp_w1.size(), 0);
        check("w1_empty",   ow_valid[1],   1'b0);

        // R wire-through on inst1: same-cycle valid/data, ready mirrored.
        step();
        ir_ready[1] = 1'b0;
        or_valid[1] = 1'b1; or_data[1] = 32'hDEADBEEF; or_resp[1] = 2'd2; or_id[1] = 4'd5; or_last[1] = 1'b1;
        #1;
        check("r1_valid_pass", ir_valid[1], 1'b1);
        check("r1_data_pass",  ir_data[1],  32'hDEADBEEF);
        check("r1_id_pass",    ir_id[1],    4'd5);
        check("r1_ready_lo",   or_ready[1], 1'b0);
        ir_ready[1] = 1'b1;
        #1;
        check("r1_ready_hi",   or_ready[1], 1'b1);
        check("r1_idle",       idle[1],     1'b1);
        or_valid[1] = 1'b0;
        #1;
        check("r1_valid_drop", ir_valid[1], 1'b0);

        // Three stored B beats are discarded the moment reset rises.
        step();
        ib_ready[1] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ob_valid[1] = 1'b1; ob_resp[1] = 2'(i); ob_id[1] = 4'(8 + i);
            @(negedge clk);
            check($sformatf("b1_accept_%0d", i), ob_ready[1], 1'b1);
            step();
        end
        ob_valid[1] = 1'b0;
        @(negedge clk);
        check("b1_stored_valid", ib_valid[1], 1'b1);
        check("b1_stored_idle",  idle[1],     1'b0);
        step();
        rst[1] = 1'b1;
        #1;
        check("b1_rst_valid", ib_valid[1], 1'b0);
        check("b1_rst_idle",  idle[1],     1'b1);
        check("b1_rst_ready", ob_ready[1], 1'b1);
        repeat (2) step();
        rst[1] = 1'b0;
        ib_ready[1] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("b1_no_stale_%0d", i), ib_valid[1], 1'b0);
            step();
        end
        ob_valid[1] = 1'b1; ob_resp[1] = 2'd1; ob_id[1] = 4'hC;
        exp_b1.push_back({2'd1, 4'hC});
        step();
        ob_valid[1] = 1'b0;
        repeat (3) step();
        @(negedge clk);
        check("b1_fresh_drained", exp_b1.size(), 0);

        // DEPTH=8 AR channel: 20 transfers with random stalls on both sides.
        step();
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    int          budget;
                    bit          acc;
                    logic [31:0] a;
                    budget = 0;
                    acc = 1'b0;
                    a = 32'h2000 + 32'(i) * 32'h40;
                    iar_valid[2] = 1'b1; iar_addr[2] = a; iar_id[2] = 4'(i);
                    iar_len[2] = 8'(i); iar_burst[2] = 2'd1;
                    while (!acc && budget < 200) begin
                        @(negedge clk);
                        if (iar_ready[2]) begin
                            acc = 1'b1;
                            exp_ar2.push_back({a, 4'(i), 8'(i), 2'd1});
                        end
                        step();
                        budget++;
                    end
                    check($sformatf("ar2_accept_%0d", i), acc, 1'b1);
                    iar_valid[2] = 1'b0;
                    if ($urandom_range(0, 2) == 0) step();
                end
                ar_done = 1'b1;
            end
            begin
                int n;
                n = 0;
                while (!ar_done && n < 4000) begin
                    step();
                    oar_ready[2] = ($urandom_range(0, 2) == 0);
                    n++;
                end
                oar_ready[2] = 1'b1;
            end
        join
        oar_ready[2] = 1'b1;
        for (int k = 0; k < 50 && exp_ar2.size() != 0; k++) step();
        step();
        @(negedge clk);
        check("ar2_drained", exp_ar2.size(), 0);
        check("ar2_count",   ar_pops,        20);
        check("ar2_idle",    idle[2],        1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/axi4_retime_param.md
AXI4_RETIME_PARAM -- requirements
Module: axi4_retime_param

Interface
REQ-001 Parameter ADDR_W, default 32: AW/AR address width.
REQ-002 Parameter DATA_W, default 32: W/R data width; WSTRB width is DATA_W/8.
REQ-003 Parameter ID_W, default 4: AXI ID width on AW, B, AR and R.
REQ-004 Parameter DEPTH, default 2: per-channel buffer depth; power of two, 2 to 16.
REQ-005 Parameter PASS_MASK, default 5'b00000: per-channel pass-through select; bit 0 AW, bit 1 W, bit 2 B, bit 3 AR, bit 4 R; 1 = wire-through, no storage.
REQ-006 clk_i  input  1  clock; all state on rising edge.
REQ-007 rst_i  input  1  reset, asynchronous, active-high.
REQ-008 inport_aw{valid,addr,id,len,burst}_i / inport_awready_o  in/out  1,ADDR_W,ID_W,8,2 / 1  upstream write address channel.
REQ-009 inport_w{valid,data,strb,last}_i / inport_wready_o  in/out  1,DATA_W,DATA_W/8,1 / 1  upstream write data channel.
REQ-010 inport_b{valid,resp,id}_o / inport_bready_i  out/in  1,2,ID_W / 1  upstream write response channel.
REQ-011 inport_ar{valid,addr,id,len,burst}_i / inport_arready_o  in/out  same widths as AW  upstream read address channel.
REQ-012 inport_r{valid,data,resp,id,last}_o / inport_rready_i  out/in  1,DATA_W,2,ID_W,1 / 1  upstream read data channel.
REQ-013 outport_* mirror of REQ-008..012 with directions reversed  downstream side.
REQ-014 idle_o  output  1  high when every buffered channel is empty.

Function
REQ-015 Each channel with PASS_MASK bit 0 shall contain one FIFO of DEPTH entries carrying the channel payload (all fields except valid/ready) in order.
REQ-016 Each channel with PASS_MASK bit 1 shall connect valid, ready and payload combinationally, source to sink, with zero latency and no state.
REQ-017 A push shall occur on a source valid and ready cycle, and a pop on a sink valid and ready cycle; payload order shall be preserved exactly.
REQ-018 Source ready shall be high when the stored count is below DEPTH. It shall depend only on registered state and never on source valid or sink ready.
REQ-019 Sink valid shall be high when the stored count is non-zero. It shall depend only on registered state.
REQ-020 Latency from a push into an empty FIFO to sink valid shall be exactly 1 cycle; there is no combinational bypass.
REQ-021 Simultaneous push and pop shall leave the count unchanged and advance both pointers.
REQ-022 When the FIFO is full and the sink pops, the push shall still be refused that cycle, because ready is registered; ready shall rise the following cycle.
REQ-023 Read and write pointers shall be log2(DEPTH) bits and wrap from DEPTH-1 to 0. The count shall be log2(DEPTH)+1 bits, saturate at neither bound, and never exceed DEPTH.
REQ-024 Sink payload shall equal the entry at the read pointer; its value while valid is low is don't-care.
REQ-025 idle_o shall be the AND of (count == 0) over all buffered channels; it shall be 1 if PASS_MASK = 5'b11111.
REQ-026 Full throughput shall be 1 beat per cycle per channel when the sink holds ready high and DEPTH >= 2.

Reset
REQ-027 While rst_i is high, every count and pointer shall be 0.
REQ-028 While rst_i is high, buffered-channel valid outputs shall be 0, buffered-channel ready outputs shall be 1, and idle_o shall be 1.
REQ-029 Storage RAM shall not be reset.
REQ-030 Reset asserted mid-burst shall discard all stored beats immediately, with no partial pops after release.
REQ-031 Pass-through channels shall be unaffected by reset.

Structure
REQ-032 Channel index constants (CH_AW=0 .. CH_R=4) and the payload width functions shall live in the shared package axi4_retime_pkg.
REQ-033 A single sub-module axi4_retime_fifo (parameters WIDTH, DEPTH) shall be instantiated per buffered channel, selected by generate on PASS_MASK.

Verification
REQ-034 DEPTH=2, PASS_MASK=0: push AW addr 0x1000 id 3 at cycle 0 -> outport_awvalid_o=1 with addr 0x1000, id 3 at cycle 1; idle_o=0 until it is popped.
REQ-035 DEPTH=4, outport_wready_i=0, 6 W beats offered -> 4 accepted, inport_wready_o=0 after the 4th; release ready -> beats emerge in order 0..3.
REQ-036 DEPTH=2, full FIFO, simultaneous pop and offered push -> push refused that cycle, accepted next cycle; count goes 2,1,2.
REQ-037 PASS_MASK=5'b10000: R beat rdata 0xDEADBEEF -> inport_rvalid_o and data appear the same cycle; outport_rready_o mirrors inport_rready_i.
REQ-038 DEPTH=8, 20 random-stall AR transfers -> all 20 delivered in order with no loss or duplication, and pointer wrap is exercised.
REQ-039 Assert rst_i with 3 B beats stored -> inport_bvalid_o=0 and idle_o=1 within the same cycle; no stale beats after release.
